// File: rtl/arbitro_registrador_pkg.sv
// Shared definitions for the round-robin arbiter/sequencer in front of the shared register.
package arbitro_registrador_pkg;

  localparam int unsigned DEFAULT_PARAM_BITS = 9;
  localparam int unsigned DEFAULT_N_REQ      = 4;
  localparam int unsigned DEFAULT_IDX_W      = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StLoad  = 2'd2,
    StAck   = 2'd3
  } state_e;

endpackage

// File: rtl/arbitro_registrador_seletor_rr.sv
// Round-robin selector: first pending request strictly after last_idx, wrapping around.
module seletor_rr
  import arbitro_registrador_pkg::*;
#(
  parameter int unsigned N_REQ = DEFAULT_N_REQ,
  parameter int unsigned IDX_W = DEFAULT_IDX_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  logic [N_REQ-1:0] rot;
  int unsigned      start;
  int unsigned      enc;

  always_comb begin
    start = (32'(last_idx) + 32'd1) % N_REQ;
    // Rotate so the highest-priority requester lands at bit 0.
    rot   = N_REQ'({req, req} >> start);
    enc   = 0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) enc = unsigned'(i);
    end
    valid  = |req;
    winner = IDX_W'((start + enc) % N_REQ);
  end

endmodule

// File: rtl/arbitro_registrador.sv
// Arbitrates N_REQ requesters onto one shared load-enabled register: grant, load, then ack.
module arbitro_registrador
  import arbitro_registrador_pkg::*;
#(
  parameter int unsigned PARAM_BITS = DEFAULT_PARAM_BITS,
  parameter int unsigned N_REQ      = DEFAULT_N_REQ,
  parameter int unsigned IDX_W      = DEFAULT_IDX_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*PARAM_BITS-1:0] data_in_flat,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            ack,
  output logic [IDX_W-1:0]            owner_idx,
  output logic                        busy,
  output logic [PARAM_BITS-1:0]       reg_data_in,
  output logic                        reg_load
);

  state_e                state_q, state_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [PARAM_BITS-1:0] data_q, data_d;
  logic [PARAM_BITS-1:0] data_arr [N_REQ];
  logic                  sel_valid;
  logic [IDX_W-1:0]      sel_winner;

  for (genvar i = 0; i < int'(N_REQ); i++) begin : g_unpack
    assign data_arr[i] = data_in_flat[i*PARAM_BITS +: PARAM_BITS];
  end

  seletor_rr #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_seletor (
    .req     (req),
    .last_idx(last_q),
    .valid   (sel_valid),
    .winner  (sel_winner)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          owner_d = sel_winner;
          gnt_d   = N_REQ'(1) << sel_winner;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (req[owner_q]) begin
          data_d  = data_arr[owner_q];
          state_d = StLoad;
        end else begin
          // Requester withdrew before its word was taken: release without ack.
          gnt_d   = '0;
          state_d = StIdle;
        end
      end
      StLoad: state_d = StAck;
      StAck: begin
        last_d  = owner_q;
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  // data_q only changes on entry to LOAD, so the register input stays stable otherwise.
  assign gnt         = gnt_q;
  assign owner_idx   = owner_q;
  assign busy        = (state_q != StIdle);
  assign reg_load    = (state_q == StLoad);
  assign reg_data_in = data_q;
  assign ack         = (state_q == StAck) ? (N_REQ'(1) << owner_q) : '0;

endmodule

// File: tb/tb_arbitro_registrador.sv
// Self-checking bench for arbitro_registrador: transfer-level model plus directed scenarios.
module tb_arbitro_registrador;

  localparam int NB = 9;
  localparam int NR = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NB-1:0]   dw [NR];
  logic [NR*NB-1:0] data_in_flat;
  logic [NR-1:0]   gnt, ack;
  logic [IW-1:0]   owner_idx;
  logic            busy, reg_load;
  logic [NB-1:0]   reg_data_in;

  assign data_in_flat = {dw[3], dw[2], dw[1], dw[0]};

  arbitro_registrador #(
    .PARAM_BITS(NB),
    .N_REQ     (NR),
    .IDX_W     (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data_in_flat(data_in_flat),
    .gnt         (gnt),
    .ack         (ack),
    .owner_idx   (owner_idx),
    .busy        (busy),
    .reg_data_in (reg_data_in),
    .reg_load    (reg_load)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer model: m_age counts cycles into the current transfer (0 = none in progress).
  int            m_age;
  int            m_owner;
  int            m_last;
  logic [NB-1:0] m_data;
  int            cyc = 0;

  function automatic int pick(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (r[(last + k) % NR]) return (last + k) % NR;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age   <= 0;
      m_owner <= 0;
      m_last  <= NR - 1;
      m_data  <= '0;
    end else begin
      if (m_age == 0) begin
        if (req != 0) begin
          m_owner <= pick(req, m_last);
          m_age   <= 1;
        end
      end else if (m_age == 1) begin
        if (req[m_owner]) begin
          m_data <= dw[m_owner];
          m_age  <= 2;
        end else begin
          m_age <= 0;
        end
      end else if (m_age == 2) begin
        m_age <= 3;
      end else begin
        m_last <= m_owner;
        m_age  <= 0;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // The shared register lives outside the block and is never reset here.
  logic [NB-1:0] shadow = '0;
  always @(posedge clk) if (reg_load) shadow <= reg_data_in;

  int            load_owner[$];
  logic [NB-1:0] load_data[$];
  int            load_cyc[$];
  logic [NR-1:0] ack_log[$];

  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt", 32'(gnt), (m_age != 0) ? (32'd1 << m_owner) : 32'd0);
      chk("ack", 32'(ack), (m_age == 3) ? (32'd1 << m_owner) : 32'd0);
      chk("owner_idx", 32'(owner_idx), 32'(m_owner));
      chk("busy", 32'(busy), 32'(m_age != 0));
      chk("reg_load", 32'(reg_load), 32'(m_age == 2));
      chk("reg_data_in", 32'(reg_data_in), 32'(m_data));
      if (reg_load) begin
        load_owner.push_back(int'(owner_idx));
        load_data.push_back(reg_data_in);
        load_cyc.push_back(cyc);
      end
      if (ack != 0) ack_log.push_back(ack);
    end
  end

  task automatic clear_logs();
    load_owner.delete();
    load_data.delete();
    load_cyc.delete();
    ack_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  // Hold each request until its own ack, then drop it.
  task automatic serve_all();
    int n = 0;
    while (req != 0 && n < 200) begin
      @(negedge clk);
      req = req & ~ack;
      n++;
    end
    chk("serve_timeout", 32'(req != 0), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [NB-1:0] prev;
    logic [NB-1:0] pat [4];
    int exp2 [5];
    int n;
    int acks;
    for (int i = 0; i < NR; i++) dw[i] = '0;
    pat  = '{9'h1FF, 9'h000, 9'h1FF, 9'h000};
    exp2 = '{0, 1, 2, 3, 0};

    // Reset values and a single transfer from requester 0.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner_idx), 32'd0);
    chk("rst_data", 32'(reg_data_in), 32'd0);
    dw[0] = 9'h1A5;
    req   = 4'b0001;
    @(negedge clk);
    chk("t1_gnt_next", 32'(gnt), 32'h1);
    serve_all();
    chk("t1_busy_low", 32'(busy), 32'd0);
    chk("t1_nloads", 32'(load_data.size()), 32'd1);
    if (load_data.size() == 1) chk("t1_load", 32'(load_data[0]), 32'h1A5);
    chk("t1_nacks", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() == 1) chk("t1_ack", 32'(ack_log[0]), 32'h1);
    chk("t1_shadow", 32'(shadow), 32'h1A5);

    // All four held: strict rotation, one transfer every 4 cycles.
    do_reset();
    for (int i = 0; i < NR; i++) dw[i] = NB'(9'h100 + i);
    req  = 4'b1111;
    n    = 0;
    acks = 0;
    while (acks < 5 && n < 100) begin
      @(negedge clk);
      if (ack != 0) acks++;
      n++;
    end
    req = '0;
    chk("t2_timeout", 32'(acks), 32'd5);
    repeat (2) @(negedge clk);
    chk("t2_nloads", 32'(load_owner.size()), 32'd5);
    if (load_owner.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("t2_order", 32'(load_owner[i]), 32'(exp2[i]));
        chk("t2_data", 32'(load_data[i]), 32'h100 + 32'(exp2[i]));
        if (i > 0) chk("t2_spacing", 32'(load_cyc[i] - load_cyc[i-1]), 32'd4);
      end
    end

    // Wrap past the top index: last=2, then 0 and 2 pending -> 0 first.
    do_reset();
    dw[0] = 9'h011;
    dw[2] = 9'h022;
    req   = 4'b0100;
    serve_all();
    clear_logs();
    req = 4'b0101;
    serve_all();
    chk("t3_nloads", 32'(load_owner.size()), 32'd2);
    if (load_owner.size() == 2) begin
      chk("t3_first", 32'(load_owner[0]), 32'd0);
      chk("t3_second", 32'(load_owner[1]), 32'd2);
    end

    // Abort during GRANT; pending requester 3 is served next.
    do_reset();
    dw[1] = 9'h0AA;
    dw[3] = 9'h133;
    req   = 4'b0010;
    @(negedge clk);
    chk("t4_gnt1", 32'(gnt), 32'h2);
    req = 4'b1000;
    @(negedge clk);
    chk("t4_abort_gnt", 32'(gnt), 32'd0);
    chk("t4_abort_busy", 32'(busy), 32'd0);
    serve_all();
    chk("t4_nloads", 32'(load_owner.size()), 32'd1);
    if (load_owner.size() == 1) chk("t4_owner", 32'(load_owner[0]), 32'd3);
    chk("t4_nacks", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() == 1) chk("t4_ack", 32'(ack_log[0]), 32'h8);

    // Asynchronous reset in the middle of LOAD.
    do_reset();
    prev  = shadow;
    dw[0] = 9'h0FF;
    dw[1] = 9'h0C3;
    req   = 4'b0001;
    n     = 0;
    while (!reg_load && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_load", 32'(reg_load), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t5_gnt", 32'(gnt), 32'd0);
    chk("t5_ack", 32'(ack), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_load", 32'(reg_load), 32'd0);
    chk("t5_data", 32'(reg_data_in), 32'd0);
    chk("t5_owner", 32'(owner_idx), 32'd0);
    repeat (2) @(negedge clk);
    chk("t5_shadow_kept", 32'(shadow), 32'(prev));
    clear_logs();
    req = 4'b0011;
    rst = 1'b0;
    serve_all();
    chk("t5_nloads", 32'(load_owner.size()), 32'd2);
    if (load_owner.size() == 2) begin
      chk("t5_first", 32'(load_owner[0]), 32'd0);
      chk("t5_second", 32'(load_owner[1]), 32'd1);
    end

    // Full-width data on requester 2.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clear_logs();
      dw[2] = pat[i];
      req   = 4'b0100;
      serve_all();
      chk("t6_nloads", 32'(load_data.size()), 32'd1);
      if (load_data.size() == 1) chk("t6_data", 32'(load_data[0]), 32'(pat[i]));
      chk("t6_shadow", 32'(shadow), 32'(pat[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
